// File: rtl/normalize_iter.sv
// Iterative post-add normalizer feeding the rounder: folds a carry-out with sticky,
// or left-shifts out leading zeros up to STEP places per cycle without going below EMIN.
module normalize_iter #(
    parameter int INTn = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    parameter int STEP = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   negIn,
    input  logic signed [NEXP+1:0] expIn,
    input  logic        [INTn:0]   sigIn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   negOut,
    output logic signed [NEXP+1:0] expOut,
    output logic        [INTn-1:0] sigOut
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int EW  = NEXP + 2;
    localparam int LZW = $clog2(INTn + 1);
    localparam int CW  = (EW + 1 > LZW) ? EW + 1 : LZW + 1;

    localparam logic signed [EW-1:0] EMIN = EW'(2 - (1 << (NEXP - 1)));
    localparam logic signed [EW-1:0] ONE  = 1;

    if (STEP < 1 || STEP > INTn || NSIG >= INTn) begin : gParamCheck
        $error("normalize_iter: illegal parameter combination");
    end

    logic [1:0]             state;
    logic [CW-1:0]          lz;
    logic [CW-1:0]          room;
    logic [CW-1:0]          amt;
    logic signed [EW:0]     expDiff;
    logic [INTn-1:0]        sigShift;
    logic signed [EW-1:0]   expShift;

    // Leading-zero count of the working significand, saturated at the per-cycle step.
    function automatic logic [CW-1:0] leadZerosSat(input logic [INTn-1:0] v);
        logic [CW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = INTn - 1; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + CW'(1);
            end
        end
        if (n > CW'(STEP)) n = CW'(STEP);
        return n;
    endfunction

    always_comb begin
        lz       = leadZerosSat(sigOut);
        expDiff  = $signed({expOut[EW-1], expOut}) - $signed({EMIN[EW-1], EMIN});
        room     = (!expDiff[EW] && (expDiff != '0)) ? CW'(expDiff) : '0;
        amt      = (lz < room) ? lz : room;
        sigShift = sigOut << amt;
        expShift = expOut - $signed(EW'(amt));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            negOut <= 1'b0;
            expOut <= '0;
            sigOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        negOut <= negIn;
                        if (sigIn[INTn]) begin
                            // Right shift by one keeps the dropped bit as sticky in the LSB.
                            sigOut <= {sigIn[INTn:2], sigIn[1] | sigIn[0]};
                            expOut <= expIn + ONE;
                            state  <= DONE;
                        end else if (sigIn == '0) begin
                            sigOut <= '0;
                            expOut <= EMIN;
                            state  <= DONE;
                        end else begin
                            sigOut <= sigIn[INTn-1:0];
                            expOut <= expIn;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (amt == '0) begin
                        state <= DONE;
                    end else begin
                        sigOut <= sigShift;
                        expOut <= expShift;
                        // Finish on the shift that normalizes or reaches EMIN; no idle check cycle.
                        if (sigShift[INTn-1] || (amt == room)) state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_iter.sv
// Self-checking bench for normalize_iter: directed vectors, random traffic against a
// behavioural model, handshake stall, back-to-back traffic and asynchronous reset.
module tb_normalize_iter;

    localparam int INTN = 32;
    localparam int NEXP = 8;
    localparam int STEP = 8;
    localparam int EMIN = -126;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                negIn = 1'b0;
    logic signed [9:0]   expIn = '0;
    logic [INTN:0]       sigIn = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                negOut;
    logic signed [9:0]   expOut;
    logic [INTN-1:0]     sigOut;

    int checks = 0;
    int errors = 0;

    normalize_iter #(.INTn(INTN), .NEXP(NEXP), .NSIG(23), .STEP(STEP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .negIn(negIn), .expIn(expIn), .sigIn(sigIn),
        .out_valid(out_valid), .out_ready(out_ready),
        .negOut(negOut), .expOut(expOut), .sigOut(sigOut)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected result and latency from the arithmetic rules of the normalizer.
    task automatic model(input logic [32:0] s, input int e,
                         output logic [31:0] es, output logic signed [9:0] ee, output int elat);
        int nlz;
        int sh;
        if (s[32]) begin
            es   = 32'(s >> 1) | {31'b0, s[0]};
            ee   = 10'(e + 1);
            elat = 1;
        end else if (s == '0) begin
            es   = '0;
            ee   = 10'(EMIN);
            elat = 1;
        end else begin
            nlz = 0;
            while (!s[31 - nlz]) nlz++;
            if (e <= EMIN)          sh = 0;
            else if (nlz < e - EMIN) sh = nlz;
            else                    sh = e - EMIN;
            es   = s[31:0] << sh;
            ee   = 10'(e - sh);
            elat = (sh == 0) ? 2 : (sh + STEP - 1) / STEP + 1;
        end
    endtask

    // Drives one transaction from IDLE, measures latency, then completes it.
    task automatic doTxn(input logic n, input int e, input logic [32:0] s,
                         output logic oNeg, output logic signed [9:0] oExp,
                         output logic [31:0] oSig, output int oLat, output logic oReadyAfter);
        int cnt;
        negIn = n; expIn = 10'(e); sigIn = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        negIn = 1'($urandom); expIn = 10'($urandom); sigIn = {1'($urandom), 32'($urandom)};
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        oNeg = negOut; oExp = expOut; oSig = sigOut; oLat = cnt;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        oReadyAfter = in_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        checks++; if (negOut !== 1'b0)    begin errors++; $display("FAIL reset negOut got %b want 0", negOut); end
        checks++; if (expOut !== 10'sd0)  begin errors++; $display("FAIL reset expOut got %0d want 0", expOut); end
        checks++; if (sigOut !== 32'h0)   begin errors++; $display("FAIL reset sigOut got %h want 0", sigOut); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [32:0]       vSig [10];
        int                vExp [10];
        logic              vNeg [10];
        logic [31:0]       wSig [10];
        int                wExp [10];
        int                wLat [10];
        logic              oNeg, oRdy;
        logic signed [9:0] oExp;
        logic [31:0]       oSig;
        int                oLat;
        vSig = '{33'h1_0000_0003, 33'h0_8000_0000, 33'h0_0000_0800, 33'h0_0000_0001, 33'h0_0000_0001,
                 33'h0_0000_0000, 33'h1_0000_0001, 33'h0_0000_0001, 33'h0_0000_0001, 33'h0_0080_0000};
        vExp = '{5, 0, 10, -120, -130, 37, -5, 100, -126, 0};
        vNeg = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        wSig = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0040, 32'h0000_0001,
                 32'h0000_0000, 32'h8000_0001, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
        wExp = '{6, 0, -10, -126, -130, -126, -4, 69, -126, -8};
        wLat = '{1, 2, 4, 2, 2, 1, 1, 5, 2, 2};
        for (int i = 0; i < 10; i++) begin
            doTxn(vNeg[i], vExp[i], vSig[i], oNeg, oExp, oSig, oLat, oRdy);
            checks++; if (oSig !== wSig[i]) begin errors++; $display("FAIL dir%0d sigOut got %h want %h", i, oSig, wSig[i]); end
            checks++; if (oExp !== 10'(wExp[i])) begin errors++; $display("FAIL dir%0d expOut got %0d want %0d", i, oExp, wExp[i]); end
            checks++; if (oNeg !== vNeg[i]) begin errors++; $display("FAIL dir%0d negOut got %b want %b", i, oNeg, vNeg[i]); end
            checks++; if (oLat != wLat[i]) begin errors++; $display("FAIL dir%0d latency got %0d want %0d", i, oLat, wLat[i]); end
            checks++; if (oRdy !== 1'b1) begin errors++; $display("FAIL dir%0d in_ready after got %b want 1", i, oRdy); end
        end
    endtask

    task automatic test_random();
        logic [32:0]       s;
        logic [31:0]       x;
        int                e, kind, elat, oLat;
        logic              n, oNeg, oRdy;
        logic [31:0]       es, oSig;
        logic signed [9:0] ee, oExp;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 4));
            n = 1'($urandom);
            e = int'($urandom_range(0, 600)) - 250;
            x = $urandom;
            x = x >> $urandom_range(0, 31);
            if (x == 0) x = 32'h1;
            case (kind)
                0: s = {1'b1, 32'($urandom)};
                1: s = '0;
                3: begin s = {1'b0, x}; e = int'($urandom_range(0, 30)) - 140; end
                default: s = {1'b0, x};
            endcase
            model(s, e, es, ee, elat);
            doTxn(n, e, s, oNeg, oExp, oSig, oLat, oRdy);
            checks++; if (oSig !== es) begin errors++; $display("FAIL rnd%0d sigOut got %h want %h (sigIn %h expIn %0d)", i, oSig, es, s, e); end
            checks++; if (oExp !== ee) begin errors++; $display("FAIL rnd%0d expOut got %0d want %0d (sigIn %h expIn %0d)", i, oExp, ee, s, e); end
            checks++; if (oNeg !== n)  begin errors++; $display("FAIL rnd%0d negOut got %b want %b", i, oNeg, n); end
            checks++; if (oLat != elat) begin errors++; $display("FAIL rnd%0d latency got %0d want %0d (sigIn %h expIn %0d)", i, oLat, elat, s, e); end
        end
    endtask

    task automatic test_handshake();
        int cnt;
        negIn = 1'b1; expIn = 10'sd10; sigIn = 33'h0_0000_0800; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        checks++; if (cnt != 4) begin errors++; $display("FAIL hs latency got %0d want 4", cnt); end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; negIn = 1'b0; expIn = 10'sd3; sigIn = 33'h1_FFFF_FFFF;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs%0d out_valid got %b want 1", k, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL hs%0d in_ready got %b want 0", k, in_ready); end
            checks++; if (sigOut !== 32'h8000_0000) begin errors++; $display("FAIL hs%0d sigOut got %h want 80000000", k, sigOut); end
            checks++; if (expOut !== -10'sd10) begin errors++; $display("FAIL hs%0d expOut got %0d want -10", k, expOut); end
            checks++; if (negOut !== 1'b1) begin errors++; $display("FAIL hs%0d negOut got %b want 1", k, negOut); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL hs release in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs release out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs idle out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [32:0]       s;
        int                e, elat, cnt;
        logic              n;
        logic [31:0]       es;
        logic signed [9:0] ee;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n = 1'($urandom);
            e = int'($urandom_range(0, 300)) - 150;
            s = {1'($urandom_range(0, 3) == 0), 32'($urandom) >> $urandom_range(0, 31)};
            model(s, e, es, ee, elat);
            negIn = n; expIn = 10'(e); sigIn = s; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cnt = 1;
            while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
            checks++; if (cnt != elat) begin errors++; $display("FAIL b2b%0d latency got %0d want %0d", i, cnt, elat); end
            checks++; if (sigOut !== es) begin errors++; $display("FAIL b2b%0d sigOut got %h want %h", i, sigOut, es); end
            checks++; if (expOut !== ee) begin errors++; $display("FAIL b2b%0d expOut got %0d want %0d", i, expOut, ee); end
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d in_ready got %b want 1", i, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic              oNeg, oRdy;
        logic signed [9:0] oExp;
        logic [31:0]       oSig;
        int                oLat;
        int                seen;
        negIn = 1'b1; expIn = 10'sd100; sigIn = 33'h0_0000_0001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
        checks++; if (sigOut !== 32'h0)   begin errors++; $display("FAIL rstmid sigOut got %h want 0", sigOut); end
        checks++; if (expOut !== 10'sd0)  begin errors++; $display("FAIL rstmid expOut got %0d want 0", expOut); end
        checks++; if (negOut !== 1'b0)    begin errors++; $display("FAIL rstmid negOut got %b want 0", negOut); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid stray out_valid cycles got %0d want 0", seen); end
        doTxn(1'b0, 5, 33'h1_0000_0003, oNeg, oExp, oSig, oLat, oRdy);
        checks++; if (oSig !== 32'h8000_0001) begin errors++; $display("FAIL rstmid after sigOut got %h want 80000001", oSig); end
        checks++; if (oLat != 1) begin errors++; $display("FAIL rstmid after latency got %0d want 1", oLat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
